// File: rtl/stream_pattern_pkg.sv
// rtl/stream_pattern_pkg.sv - shared types and LFSR tap constants for stream_pattern_tx
package stream_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    INC   = 2'd0,
    CONST = 2'd1,
    LFSR  = 2'd2,
    ALT   = 2'd3
  } mode_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Maximal-length tap masks for the shift-left Fibonacci form; 8 bits is the reference width.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      4:       return 32'h0000_000C;
      16:      return 32'h0000_B400;
      32:      return 32'h8020_0003;
      default: return {24'h0, LFSR_TAPS};
    endcase
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// rtl/lfsr_next.sv - combinational next state of a Fibonacci LFSR (shift left, parity feedback into bit 0)
module lfsr_next
  import stream_pattern_pkg::*;
#(
  parameter int               DSIZE = 8,
  parameter logic [DSIZE-1:0] TAPS  = DSIZE'(lfsr_taps(DSIZE))
) (
  input  logic [DSIZE-1:0] cur,
  output logic [DSIZE-1:0] nxt
);

  assign nxt = {cur[DSIZE-2:0], ^(cur & TAPS)};

endmodule

// File: rtl/stream_pattern_tx.sv
// rtl/stream_pattern_tx.sv - burst pattern generator on a valid/ready stream
// Optional trailing checksum beat: STREAM_PATTERN_TX_CHECKSUM_EN
module stream_pattern_tx
  import stream_pattern_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int LSIZE = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic [LSIZE-1:0] len,
  input  logic [1:0]       mode,
  input  logic [DSIZE-1:0] seed,
  output logic             busy,
  output logic             done,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  state_t           state, state_nxt;
  mode_t            mode_r;
  logic [LSIZE-1:0] rem;
  logic [DSIZE-1:0] lfsr_nxt;
  logic [DSIZE-1:0] pat_nxt;
  logic [DSIZE-1:0] first_beat;
  logic             xfer;
  logic             final_beat;
`ifdef STREAM_PATTERN_TX_CHECKSUM_EN
  logic [DSIZE-1:0] csum;
  logic             csum_beat;
`endif

  lfsr_next #(
    .DSIZE (DSIZE),
    .TAPS  (DSIZE'(lfsr_taps(DSIZE)))
  ) u_lfsr (
    .cur (out_data),
    .nxt (lfsr_nxt)
  );

  assign xfer       = out_valid && out_ready;
  // An all-zero LFSR would lock up, so a zero seed starts at 1.
  assign first_beat = (mode == LFSR && seed == '0) ? DSIZE'(1) : seed;

`ifdef STREAM_PATTERN_TX_CHECKSUM_EN
  assign final_beat = csum_beat;
`else
  assign final_beat = (rem == LSIZE'(1));
`endif

  always_comb begin
    pat_nxt = out_data;
    case (mode_r)
      INC:     pat_nxt = out_data + DSIZE'(1);
      CONST:   pat_nxt = out_data;
      LFSR:    pat_nxt = lfsr_nxt;
      ALT:     pat_nxt = ~out_data;
      default: pat_nxt = out_data;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len != '0) ? SEND : DONE;
      SEND:    if (xfer && final_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    out_valid = (state == SEND);
    done      = (state == DONE);
  end

  // Beat registers only advance on a transfer, which keeps data/last stable through stalls.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_last  <= 1'b0;
      rem       <= '0;
      mode_r    <= INC;
`ifdef STREAM_PATTERN_TX_CHECKSUM_EN
      csum      <= '0;
      csum_beat <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start && len != '0) begin
            out_data  <= first_beat;
            rem       <= len;
            mode_r    <= mode_t'(mode);
`ifdef STREAM_PATTERN_TX_CHECKSUM_EN
            out_last  <= 1'b0;
            csum      <= '0;
            csum_beat <= 1'b0;
`else
            out_last  <= (len == LSIZE'(1));
`endif
          end
        end
        SEND: begin
          if (xfer) begin
`ifdef STREAM_PATTERN_TX_CHECKSUM_EN
            if (csum_beat) begin
              out_last  <= 1'b0;
              csum_beat <= 1'b0;
            end else if (rem == LSIZE'(1)) begin
              out_data  <= csum + out_data;
              out_last  <= 1'b1;
              csum_beat <= 1'b1;
              rem       <= '0;
            end else begin
              csum      <= csum + out_data;
              out_data  <= pat_nxt;
              rem       <= rem - LSIZE'(1);
            end
`else
            if (rem == LSIZE'(1)) begin
              out_last <= 1'b0;
              rem      <= '0;
            end else begin
              out_data <= pat_nxt;
              rem      <= rem - LSIZE'(1);
              out_last <= (rem == LSIZE'(2));
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_pattern_tx.sv
// tb/tb_stream_pattern_tx.sv - scoreboard bench for stream_pattern_tx
module tb_stream_pattern_tx;

  localparam int DSIZE = 8;
  localparam int LSIZE = 16;
  localparam logic [7:0] TAPS = 8'hB8;
`ifdef STREAM_PATTERN_TX_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             rst;
  logic             start;
  logic [LSIZE-1:0] len;
  logic [1:0]       mode;
  logic [DSIZE-1:0] seed;
  logic             busy, done, out_valid, out_ready, out_last;
  logic [DSIZE-1:0] out_data;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;

  always #5 clock = ~clock;

  stream_pattern_tx #(.DSIZE(DSIZE), .LSIZE(LSIZE)) dut (
    .clock     (clock),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .mode      (mode),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_lfsr(input logic [7:0] cur);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < 8; i++)
      if (TAPS[i]) fb = fb ^ cur[i];
    return {cur[6:0], fb};
  endfunction

  function automatic int push_burst(input int n, input int m, input logic [7:0] sd);
    logic [7:0] v, sum;
    int cnt;
    v   = (m == 2 && sd == 8'h00) ? 8'h01 : sd;
    sum = 8'h00;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{data: v, last: (!CS && i == n - 1)});
      cnt++;
      sum = sum + v;
      case (m)
        0:       v = v + 8'h01;
        1:       v = sd;
        2:       v = ref_lfsr(v);
        default: v = ~v;
      endcase
    end
    if (CS && n > 0) begin
      exp_q.push_back('{data: sum, last: 1'b1});
      cnt++;
    end
    return cnt;
  endfunction

  logic       prev_stall = 1'b0;
  logic       prev_last  = 1'b0;
  logic       prev_done  = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  beat_t      got_b;

  always @(negedge clock) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
        check("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          got_b = exp_q.pop_front();
          check("data", out_data, got_b.data);
          check("last", out_last, got_b.last);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_width", prev_done, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_done  = done;
    end
  end

  function automatic logic ready_for(input int rmode, input int c);
    case (rmode)
      0:       return 1'b1;
      1:       return (c % 2 == 0);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic wait_done(input int d0, input int budget, input int rmode, input int inject);
    int c;
    c = 0;
    while (c < budget && done_cnt == d0) begin
      c++;
      out_ready = ready_for(rmode, c);
      if (c == inject) begin
        start = 1'b1; len = 16'd2; mode = 2'd1; seed = 8'h99;
      end else start = 1'b0;
      @(posedge clock); #1;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("done_seen", done_cnt - d0, 1);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic run_burst(input int n, input int m, input int sd, input int rmode,
                           input int inject, input int budget);
    int x0, d0, nb;
    x0 = xfer_cnt;
    d0 = done_cnt;
    nb = push_burst(n, m, 8'(sd));
    start = 1'b1; len = 16'(n); mode = 2'(m); seed = 8'(sd);
    out_ready = ready_for(rmode, 0);
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(d0, budget, rmode, inject);
    check("xfer_count", xfer_cnt - x0, nb);
  endtask

  initial begin
    int nb, d0, x0;
    rst = 1'b1; start = 1'b0; len = '0; mode = '0; seed = '0; out_ready = 1'b0;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    @(posedge clock); #1;
    rst = 1'b0;
    @(posedge clock); #1;

    // incrementing wrap, one-cycle latency, back-to-back, done timing, restart after done
    nb = push_burst(4, 0, 8'hFE);
    start = 1'b1; len = 16'd4; mode = 2'd0; seed = 8'hFE; out_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("first_valid", out_valid, 1);
    check("first_data", out_data, 8'hFE);
    for (int i = 1; i < nb; i++) begin
      @(posedge clock); #1;
      check("b2b_valid", out_valid, 1);
    end
    @(posedge clock); #1;
    check("done_after_last", done, 1);
    check("valid_after_last", out_valid, 0);
    @(posedge clock); #1;
    check("done_pulse_end", done, 0);
    d0 = done_cnt;
    nb = push_burst(2, 1, 8'h77);
    start = 1'b1; len = 16'd2; mode = 2'd1; seed = 8'h77;
    @(posedge clock); #1;
    start = 1'b0;
    check("restart_valid", out_valid, 1);
    wait_done(d0, 50, 0, -1);

    // alternating pattern under toggled ready
    run_burst(3, 3, 8'hA5, 1, -1, 50);

    // zero-length burst
    d0 = done_cnt;
    start = 1'b1; len = 16'd0; mode = 2'd0; seed = 8'h12;
    @(posedge clock); #1;
    start = 1'b0;
    check("len0_busy", busy, 1);
    check("len0_done", done, 1);
    check("len0_valid", out_valid, 0);
    @(posedge clock); #1;
    check("len0_idle", busy, 0);
    check("len0_done_cnt", done_cnt - d0, 1);

    // start while busy is ignored
    run_burst(6, 1, 8'h3C, 0, 2, 50);

    // LFSR, including the zero-seed substitution
    run_burst(8, 2, 8'h00, 0, -1, 50);
    run_burst(10, 2, 8'h5A, 2, -1, 100);

    run_burst(3, 0, 8'h10, 0, -1, 50);
    run_burst(1, 3, 8'hC3, 0, -1, 50);
    run_burst(12, 0, 8'hF8, 2, -1, 100);

    // reset during the second beat
    x0 = xfer_cnt;
    nb = push_burst(5, 0, 8'h40);
    start = 1'b1; len = 16'd5; mode = 2'd0; seed = 8'h40; out_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    check("beat2_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_data", out_data, 0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clock);
    #1;
    rst = 1'b0;
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_xfers", xfer_cnt - x0, 1);
    run_burst(5, 0, 8'h40, 0, -1, 50);

    // maximum length
    run_burst(16'hFFFF, 0, 8'h00, 0, -1, 70000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_pattern_tx.md
STREAM_PATTERN_TX -- requirements
Module: stream_pattern_tx

Interface
REQ-001 The block SHALL have parameter DSIZE, default 8, giving the width of the data beat.
REQ-002 The block SHALL have parameter LSIZE, default 16, giving the width of the beat count.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port clock, input, 1 bit: the single rising-edge clock.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port start, input, 1 bit: single-cycle request to begin a burst; sampled only in IDLE.
REQ-007 Port len, input, LSIZE bits: number of payload beats in the burst; sampled with start.
REQ-008 Port mode, input, 2 bits: pattern select; sampled with start.
REQ-009 Port seed, input, DSIZE bits: pattern seed; sampled with start.
REQ-010 Port busy, output, 1 bit: high while the state is not IDLE.
REQ-011 Port done, output, 1 bit: one-cycle pulse when a burst completes.
REQ-012 Port out_data, output, DSIZE bits: data stream payload.
REQ-013 Port out_valid, output, 1 bit: stream valid.
REQ-014 Port out_ready, input, 1 bit: stream ready from the downstream consumer.
REQ-015 Port out_last, output, 1 bit: marks the final beat of the burst.

Function
REQ-016 The block SHALL implement three states: IDLE, SEND and DONE.
REQ-017 In IDLE, start=1 with len!=0 SHALL latch len, mode and seed and move to SEND; start=1 with len==0 SHALL move directly to DONE and emit no beats.
REQ-018 The first beat SHALL have out_valid=1 in the cycle after start is sampled (1-cycle latency).
REQ-019 A beat SHALL transfer only on a clock edge where out_valid=1 and out_ready=1.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_last and out_valid SHALL hold stable.
REQ-021 out_valid SHALL NOT depend combinationally on out_ready.
REQ-022 Back-to-back transfers SHALL be sustained at one beat per cycle while out_ready=1.
REQ-023 Pattern by mode:
- mode 0: seed, seed+1, ... incrementing modulo 2^DSIZE (wraps from 0xFF to 0x00 when DSIZE=8).
- mode 1: constant seed.
- mode 2: Fibonacci LFSR starting at seed; a seed of 0 SHALL be replaced by 1.
- mode 3: alternating seed, ~seed, seed, ...
REQ-024 out_last SHALL be 1 on exactly the final beat of the burst: beat number len, or the checksum beat per REQ-032.
REQ-025 After the last beat transfers, the state SHALL move to DONE; DONE SHALL assert done for one cycle and return to IDLE.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 A start arriving in the cycle after done SHALL be accepted.
REQ-028 len=2^LSIZE-1 SHALL complete with no counter overflow; the beat counter SHALL be LSIZE bits wide.

Reset
REQ-029 While rst=1, asynchronously and without waiting for a clock edge: state=IDLE, out_valid=0, out_last=0, out_data=0, busy=0, done=0, and all internal counters and the checksum SHALL be 0.
REQ-030 Reset asserted mid-burst SHALL abort the burst, with no done pulse; after rst falls the block SHALL accept a new start.

Configuration
REQ-031 The block SHALL use macro STREAM_PATTERN_TX_CHECKSUM_EN to select the checksum feature.
REQ-032 With STREAM_PATTERN_TX_CHECKSUM_EN defined, the block SHALL:
- append one extra beat after the len payload beats, carrying the sum of all payload beats modulo 2^DSIZE;
- assert out_last only on that checksum beat;
- for len==0, send no beats at all.
REQ-033 Without STREAM_PATTERN_TX_CHECKSUM_EN, no checksum beat and no checksum logic SHALL exist.

Structure
REQ-034 Package stream_pattern_pkg SHALL hold:
- the state enum (IDLE/SEND/DONE);
- the mode enum (INC/CONST/LFSR/ALT);
- constant LFSR_TAPS (0xB8 for DSIZE=8).
REQ-035 The LFSR next-value logic SHALL be one sub-module, lfsr_next (combinational, DSIZE-parameterised); no other sub-modules.

Verification
REQ-036 start, len=4, mode=0, seed=0xFE, out_ready=1 -> data FE,FF,00,01 on consecutive cycles; out_last on 01; done 1 cycle later.
REQ-037 len=3, mode=3, seed=0xA5, out_ready toggled 1/0 each cycle -> data A5,5A,A5, each held stable through stalls; exactly 3 transfers.
REQ-038 start with len=0 -> no out_valid; busy for 1 cycle; done pulse; a start pulsed mid-burst is ignored (count unchanged).
REQ-039 mode=2, seed=0 -> first beat 0x01, following beats match the reference LFSR model for LFSR_TAPS.
REQ-040 Checksum build: len=3, mode=0, seed=0x10 -> 10,11,12 then 0x33 with out_last; non-checksum build has out_last on 12.
REQ-041 rst asserted on the 2nd beat of a len=5 burst -> out_valid=0 immediately, no done; a new burst then completes normally.
